rule110_scheduler: RTL
======================

# rule110_scheduler

Sequencer that evolves a circular row of `WIDTH` cellular-automaton cells under rule 110, time-multiplexing a single 3-input rule-110 cell evaluator across the row, one cell per clock. Accepts a parallel seed load, single-step and free-run commands. Exposes the committed row, a generation counter and a per-generation done pulse, for driving the output pins or a display/streaming stage in the top level.

## Interface
- `WIDTH`, 16: number of cells in the row; legal range 3..256.
- `TICK_CYCLES`, 24'd10_000_000: idle cycles inserted between generations in run mode; legal range ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `load_valid`  in  1  request to load `load_data` into the row.
- `load_data`  in  `WIDTH`  seed row; bit i is cell i.
- `load_ready`  out  1  high only in IDLE; a load completes when `load_valid && load_ready`.
- `cmd_step`  in  1  pulse or level; starts exactly one generation when accepted.
- `cmd_run`  in  1  starts free-running generations when accepted.
- `cmd_stop`  in  1  clears run mode.
- `busy`  out  1  high in every state except IDLE.
- `running`  out  1  run-mode flag.
- `gen_done`  out  1  single-cycle pulse in the COMMIT cycle.
- `row_out`  out  `WIDTH`  committed row; changes only on a load or a COMMIT edge.
- `gen_count`  out  16  generations committed since the last load or reset; wraps at 16'hFFFF → 0.

## Operation
- Neighbourhood of cell i is {row[(i+1) mod WIDTH], row[i], row[(i−1) mod WIDTH]}, MSB first. Row is circular: cell 0's right neighbour is cell WIDTH−1, and cell WIDTH−1's left neighbour is cell 0.
- Rule: 000→0, 100→0, 111→0; all other patterns →1.
- The evaluator reads only the committed row. Results go to a shadow `next_row` register, so in-place update never corrupts neighbours.
- States:
  - **IDLE**
    - `load_valid`: row ← `load_data`, `gen_count` ← 0, stay in IDLE.
    - else `cmd_run`: `running` ← 1, go to EVAL.
    - else `cmd_step`: go to EVAL.
  - **EVAL**: `idx` counts 0..WIDTH−1; `next_row[idx]` ← rule(neighbourhood(idx)); after `idx` = WIDTH−1, go to COMMIT.
  - **COMMIT**: row ← `next_row`, `gen_count` += 1, `gen_done` = 1. Go to WAIT if `running`, else IDLE.
  - **WAIT**: a down-counter runs TICK_CYCLES cycles, then `idx` ← 0 and go to EVAL. If `running` is clear, go to IDLE immediately.
- Command priority in IDLE: load > run > step. Commands arriving in non-IDLE states are ignored, except `cmd_stop`.
- `cmd_stop` in any state clears `running`:
  - In EVAL, the current generation still completes and commits, then the block returns to IDLE.
  - In WAIT, the block goes to IDLE on the next edge.
  - `cmd_stop` together with `cmd_run` in IDLE: stop wins, and the block starts a single step only if `cmd_step` is also high.
- `load_valid` outside IDLE: ignored (`load_ready` = 0); no row change.

## Timing
- Reset values: state IDLE, `row_out` = 0, `next_row` = 0, `gen_count` = 0, `running` = 0, `busy` = 0, `gen_done` = 0, `load_ready` = 1 (first cycle after reset).
- Reset mid-operation aborts immediately; the partial `next_row` is discarded.
- Step accepted at edge 0 → EVAL during cycles 1..WIDTH → `gen_done` high and new `row_out` visible in cycle WIDTH+1 → IDLE (`busy` = 0) from cycle WIDTH+2.
- Step latency is WIDTH+1 cycles; a back-to-back step can be accepted in cycle WIDTH+2.
- Run mode: `gen_done` pulses are spaced exactly WIDTH+1+TICK_CYCLES cycles apart.
- Load takes effect on the accepting edge; `row_out` shows the seed the next cycle.
- All outputs are registered except `load_ready` and `busy`, which decode state.

## Structure
- Shared package `rule110_pkg`:
  - state enum {IDLE, EVAL, COMMIT, WAIT};
  - rule-110 truth constant 8'b0110_1110, indexed by neighbourhood;
  - `GEN_COUNT_W` = 16.
- Sub-module: the team's existing `rule110` cell primitive, instantiated once. The neighbourhood mux feeds it from `idx`, with wrap-around indices computed by compare, not modulo.
- `idx` width: $clog2(WIDTH). Tick counter width: 24 bits.

## Test plan
- Reset, then load 16'h0001 and step three times → `row_out` = 16'h0003, 16'h0007, 16'h000D; `gen_count` = 3.
- Load 16'hFFFF and step → `row_out` = 16'h0000. Step again → stays 16'h0000 (all-zero fixed point).
- Step accepted at cycle 0 with WIDTH=16 → `busy` high in cycles 1..17, `gen_done` only in cycle 17, `load_ready` back at cycle 18.
- TICK_CYCLES=4, `cmd_run` from seed 16'h0001 → `gen_done` pulses 21 cycles apart. Assert `cmd_stop` mid-EVAL → that generation commits, then IDLE with `running` = 0.
- Assert `load_valid` with 16'hAAAA during EVAL → ignored, row unchanged. Load plus step in the same IDLE cycle → load applied, no generation.
- `reset` asserted in EVAL cycle 8 → next cycle: `row_out` = 0, `gen_count` = 0, IDLE, no `gen_done`.

Source files
------------

// File: rtl/rule110_pkg.sv
// Shared types and constants for the rule-110 row scheduler.
package rule110_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2,
        WAIT   = 2'd3
    } state_t;

    // Bit n gives the next cell value for neighbourhood {left, centre, right} == n.
    localparam logic [7:0] RULE110_TABLE = 8'b0110_1110;

    localparam int GEN_COUNT_W = 16;

endpackage

// File: rtl/rule110.sv
// Single rule-110 cell evaluator: table lookup on the 3-cell neighbourhood.
module rule110
    import rule110_pkg::*;
(
    input  logic left,
    input  logic center,
    input  logic right,
    output logic cell_next
);

    assign cell_next = RULE110_TABLE[{left, center, right}];

endmodule

// File: rtl/rule110_scheduler.sv
// Evolves a circular row of cells under rule 110, one cell per clock through a
// single shared evaluator, with load, single-step and free-run control.
module rule110_scheduler
    import rule110_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter logic [23:0] TICK_CYCLES = 24'd10_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    input  logic [WIDTH-1:0]       load_data,
    output logic                   load_ready,
    input  logic                   cmd_step,
    input  logic                   cmd_run,
    input  logic                   cmd_stop,
    output logic                   busy,
    output logic                   running,
    output logic                   gen_done,
    output logic [WIDTH-1:0]       row_out,
    output logic [GEN_COUNT_W-1:0] gen_count,
    output logic [1:0]             fsm_state
);

    // Handshake: a load transfers on any edge where load_valid && load_ready;
    // load_ready is a pure decode of IDLE, so it never depends on load_valid.

    localparam int              IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  left_idx;
    logic [IDX_W-1:0]  right_idx;
    logic [WIDTH-1:0]  next_row;
    logic [WIDTH-1:0]  next_row_upd;
    logic [23:0]       tick_cnt;
    logic              cell_out;

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

    // Circular neighbours by compare so non-power-of-two widths wrap correctly.
    always_comb begin
        left_idx  = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        right_idx = (idx == '0) ? LAST_IDX : idx - IDX_W'(1);
    end

    rule110 u_cell (
        .left      (row_out[left_idx]),
        .center    (row_out[idx]),
        .right     (row_out[right_idx]),
        .cell_next (cell_out)
    );

    always_comb begin
        next_row_upd      = next_row;
        next_row_upd[idx] = cell_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            next_row  <= '0;
            row_out   <= '0;
            gen_count <= '0;
            running   <= 1'b0;
            gen_done  <= 1'b0;
            tick_cnt  <= '0;
        end else begin
            gen_done <= 1'b0;
            if (cmd_stop) begin
                running <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        row_out   <= load_data;
                        gen_count <= '0;
                    end else if (cmd_run && !cmd_stop) begin
                        running <= 1'b1;
                        idx     <= '0;
                        state   <= EVAL;
                    end else if (cmd_step) begin
                        idx   <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    next_row <= next_row_upd;
                    // The commit is registered on entry so the new row and the
                    // done pulse are both visible during the COMMIT cycle.
                    if (idx == LAST_IDX) begin
                        row_out   <= next_row_upd;
                        gen_count <= gen_count + 1'b1;
                        gen_done  <= 1'b1;
                        state     <= COMMIT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                COMMIT: begin
                    if (running && !cmd_stop) begin
                        tick_cnt <= TICK_CYCLES - 24'd1;
                        state    <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (!running || cmd_stop) begin
                        state <= IDLE;
                    end else if (tick_cnt == '0) begin
                        idx   <= '0;
                        state <= EVAL;
                    end else begin
                        tick_cnt <= tick_cnt - 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
